// File: rtl/blade8_feeder.sv
// rtl/blade8_feeder.sv - operand sequencer feeding 2-bit blade pairs to the 16-lane signed bit-blade PE
//
// Latches one x/y vector pair and walks the 16 (i,j) blade-significance pairs,
// one per cycle, i-major. It also emits a PE_LAT-delayed tag describing each step.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  vector-pair handshake (in_ready depends on state only)
//   x_vec, y_vec        16 x 8-bit operands, element e at [8e+7:8e]
//   x_signed, y_signed  operands are two's complement
//   in1/sn1, in2/sn2    registered x / y blades and blade sign flags to the PE
//   blade_vld           in1/sn1/in2/sn2 carry a live blade pair
//   tag_vld/tag_shift/  PE_LAT-delayed step tag: live, i+j, first step, last step
//   tag_first/tag_last
module blade8_feeder #(
  parameter int NUM_ELEM = 16,
  parameter int PE_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NUM_ELEM-1:0] x_vec,
  input  logic [8*NUM_ELEM-1:0] y_vec,
  input  logic                  x_signed,
  input  logic                  y_signed,
  output logic [2*NUM_ELEM-1:0] in1,
  output logic [NUM_ELEM-1:0]   sn1,
  output logic [2*NUM_ELEM-1:0] in2,
  output logic [NUM_ELEM-1:0]   sn2,
  output logic                  blade_vld,
  output logic                  tag_vld,
  output logic [2:0]            tag_shift,
  output logic                  tag_first,
  output logic                  tag_last
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [3:0]            cnt;
  logic [8*NUM_ELEM-1:0] xl;
  logic [8*NUM_ELEM-1:0] yl;
  logic                  xs_l;
  logic                  ys_l;
  logic                  accept;
  logic [1:0]            bi;
  logic [1:0]            bj;

  logic [2*NUM_ELEM-1:0] nxt_in1;
  logic [2*NUM_ELEM-1:0] nxt_in2;
  logic [NUM_ELEM-1:0]   nxt_sn1;
  logic [NUM_ELEM-1:0]   nxt_sn2;

  // Step attributes registered alongside the blade drive, then delayed for the tag.
  logic [2:0]            d_shift;
  logic                  d_first;
  logic                  d_last;
  logic [5:0]            tag_pipe [PE_LAT];

  // The last step of a vector doubles as the accept slot for the next one,
  // which is what makes back-to-back pairs gapless.
  assign in_ready = (state == ST_IDLE) | ((state == ST_RUN) & (cnt == 4'd15));
  assign accept   = in_valid & in_ready;
  assign bi       = cnt[3:2];
  assign bj       = cnt[1:0];

  function automatic logic [1:0] pick(input logic [7:0] v, input logic [1:0] s);
    case (s)
      2'd0:    pick = v[1:0];
      2'd1:    pick = v[3:2];
      2'd2:    pick = v[5:4];
      default: pick = v[7:6];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      xl    <= '0;
      yl    <= '0;
      xs_l  <= 1'b0;
      ys_l  <= 1'b0;
    end else if (accept) begin
      state <= ST_RUN;
      cnt   <= 4'd0;
      xl    <= x_vec;
      yl    <= y_vec;
      xs_l  <= x_signed;
      ys_l  <= y_signed;
    end else if (state == ST_RUN) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) begin
        state <= ST_IDLE;
      end
    end
  end

  // Idle drive is all-zero so the PE sums to 0 between vectors.
  always_comb begin
    nxt_in1 = '0;
    nxt_in2 = '0;
    nxt_sn1 = '0;
    nxt_sn2 = '0;
    if (state == ST_RUN) begin
      for (int e = 0; e < NUM_ELEM; e++) begin
        nxt_in1[2*e +: 2] = pick(xl[8*e +: 8], bi);
        nxt_in2[2*e +: 2] = pick(yl[8*e +: 8], bj);
      end
      // Only the top blade of a signed operand carries the negative weight.
      nxt_sn1 = {NUM_ELEM{xs_l & (bi == 2'd3)}};
      nxt_sn2 = {NUM_ELEM{ys_l & (bj == 2'd3)}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1       <= '0;
      in2       <= '0;
      sn1       <= '0;
      sn2       <= '0;
      blade_vld <= 1'b0;
      d_shift   <= 3'd0;
      d_first   <= 1'b0;
      d_last    <= 1'b0;
    end else begin
      in1       <= nxt_in1;
      in2       <= nxt_in2;
      sn1       <= nxt_sn1;
      sn2       <= nxt_sn2;
      blade_vld <= (state == ST_RUN);
      if (state == ST_RUN) begin
        d_shift <= {1'b0, bi} + {1'b0, bj};
        d_first <= (cnt == 4'd0);
        d_last  <= (cnt == 4'd15);
      end else begin
        d_shift <= 3'd0;
        d_first <= 1'b0;
        d_last  <= 1'b0;
      end
    end
  end

  // Tag delay line: stage 0 holds the tag of the blade pair currently on the
  // PE inputs, so the output stage lines up with the PE result PE_LAT later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PE_LAT; s++) begin
        tag_pipe[s] <= 6'd0;
      end
    end else begin
      tag_pipe[0] <= {blade_vld, d_shift, d_first, d_last};
      for (int s = 1; s < PE_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign tag_vld   = tag_pipe[PE_LAT-1][5];
  assign tag_shift = tag_pipe[PE_LAT-1][4:2];
  assign tag_first = tag_pipe[PE_LAT-1][1];
  assign tag_last  = tag_pipe[PE_LAT-1][0];

endmodule
